// File: rtl/multiplicador_8bits_1_pkg.sv
// Shared constants for the shift-and-add multiplier: default operand width
// and the controller state encoding.
package multiplicador_8bits_1_pkg;

  localparam int ANCHO_DEF = 8;

  // 2'd3 is not a legal state; the controller recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/multiplicador_8bits_1_sumador.sv
// ANCHO-bit ripple adder with carry-in and carry-out. The multiplier uses it
// for H + addend with the carry-in tied low.
module multiplicador_8bits_1_sumador #(
  parameter int ANCHO = 8
) (
  input  logic [ANCHO-1:0] i_a,
  input  logic [ANCHO-1:0] i_b,
  input  logic             i_cin,
  output logic [ANCHO-1:0] o_s,
  output logic             o_cout
);

  logic [ANCHO:0] w_full;

  // Zero-extend both operands so the carry-out lands in the top bit.
  always_comb begin
    w_full = {1'b0, i_a} + {1'b0, i_b} + {{ANCHO{1'b0}}, i_cin};
  end

  assign o_s    = w_full[ANCHO-1:0];
  assign o_cout = w_full[ANCHO];

endmodule

// File: rtl/multiplicador_8bits_1.sv
// Sequential shift-and-add multiplier: PP = A * B over ANCHO iterations.
// Optional macro MULT_SIGNED_EN: treat A and B as two's complement by
// multiplying magnitudes and negating the product when the signs differ.
//
// Handshake: init is sampled only in IDLE. An accepted init at edge k puts the
// block in ITER for edges k+1..k+ANCHO (busy=1); PP is written on edge k+ANCHO
// and done pulses for the single following cycle (state FIN). PP then holds
// until the next operation completes or reset clears it.
module multiplicador_8bits_1
  import multiplicador_8bits_1_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [ANCHO-1:0]   A,
  input  logic [ANCHO-1:0]   B,
  output logic [2*ANCHO-1:0] PP,
  output logic               busy,
  output logic               done,
  output logic [1:0]         o_dbg_state
);

  localparam int CNT_W = $clog2(ANCHO) + 1;

  state_t             r_state;
  state_t             w_next;
  logic [ANCHO-1:0]   r_ma;
  logic [ANCHO-1:0]   r_h;
  logic [ANCHO-1:0]   r_l;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*ANCHO-1:0] r_pp;

  logic [ANCHO-1:0]   w_a_in;
  logic [ANCHO-1:0]   w_b_in;
  logic [ANCHO-1:0]   w_addend;
  logic [ANCHO-1:0]   w_s;
  logic               w_cout;
  logic [ANCHO:0]     w_sum;
  logic [2*ANCHO-1:0] w_prod;
  logic [2*ANCHO-1:0] w_pp_final;
  logic               w_last;

`ifdef MULT_SIGNED_EN
  logic r_neg;

  // Magnitudes of the signed operands; -2^(ANCHO-1) maps to its unsigned value.
  always_comb begin
    w_a_in = A[ANCHO-1] ? (~A + ANCHO'(1)) : A;
    w_b_in = B[ANCHO-1] ? (~B + ANCHO'(1)) : B;
  end

  // Restore the sign of the product on the way into PP.
  always_comb begin
    w_pp_final = r_neg ? (~w_prod + (2*ANCHO)'(1)) : w_prod;
  end
`else
  // Unsigned build: operands and product pass through unchanged.
  always_comb begin
    w_a_in     = A;
    w_b_in     = B;
    w_pp_final = w_prod;
  end
`endif

  // Add the multiplicand only when the current multiplier bit is set.
  always_comb begin
    w_addend = r_l[0] ? r_ma : '0;
  end

  multiplicador_8bits_1_sumador #(.ANCHO(ANCHO)) u_sumador (
    .i_a    (r_h),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  // Accumulator after this iteration's add-then-shift; the carry-out slides
  // into H's MSB so the C bit of {C,H,L} is always zero after a shift.
  always_comb begin
    w_sum  = {w_cout, w_s};
    w_prod = {w_sum, r_l[ANCHO-1:1]};
    w_last = (r_cnt == CNT_W'(ANCHO - 1));
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; the illegal encoding falls back to IDLE.
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = init ? ITER : IDLE;
      ITER:    w_next = w_last ? FIN : ITER;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture on accepted init, add-and-shift in ITER, write PP on the
  // last iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ma  <= '0;
      r_h   <= '0;
      r_l   <= '0;
      r_cnt <= '0;
      r_pp  <= '0;
`ifdef MULT_SIGNED_EN
      r_neg <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (init) begin
            r_ma  <= w_a_in;
            r_h   <= '0;
            r_l   <= w_b_in;
            r_cnt <= '0;
`ifdef MULT_SIGNED_EN
            r_neg <= A[ANCHO-1] ^ B[ANCHO-1];
`endif
          end
        end
        ITER: begin
          r_h   <= w_sum[ANCHO:1];
          r_l   <= {w_sum[0], r_l[ANCHO-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_pp <= w_pp_final;
        end
        default: ;
      endcase
    end
  end

  assign PP          = r_pp;
  assign busy        = (r_state == ITER);
  assign done        = (r_state == FIN);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multiplicador_8bits_1.sv
// Directed testbench for multiplicador_8bits_1. Inputs are driven and outputs
// sampled on the falling edge, half a cycle away from the active edge.
// Build with +define+MULT_SIGNED_EN to exercise the signed variant.
module tb_multiplicador_8bits_1;

  logic        clk;
  logic        rst;
  logic        init;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] PP;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;

  multiplicador_8bits_1 dut (
    .clk         (clk),
    .rst         (rst),
    .init        (init),
    .A           (A),
    .B           (B),
    .PP          (PP),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present operands with init for one edge (edge k); returns just
  // after edge k.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    A = a; B = b; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // Follow one operation started by start_op: busy for 8 samples, then done
  // with the product, then done falls while PP holds.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    start_op(a, b);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy/done at iter %0d: got %b/%b, want 1/0", name, i, busy, done);
      end
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done pulse: got busy=%b done=%b, want 0/1", name, busy, done);
    end
    n_checks++;
    if (PP !== exp) begin
      n_fail++;
      $display("FAIL %s product: got %h, want %h", name, PP, exp);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || PP !== exp || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL %s hold: got done=%b PP=%h st=%0d, want 0/%h/0", name, done, PP, dbg_state, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b1; A = 8'h55; B = 8'h66;
    repeat (2) @(negedge clk);
    rst = 1'b0; init = 1'b0;
    @(negedge clk);
    n_checks++;
    if (PP !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got PP=%h busy=%b done=%b, want 0000/0/0", PP, busy, done);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset state: got %0d, want 0", dbg_state);
    end
  endtask

  task automatic test_basic();
    run_op("mul_0f_0d", 8'h0F, 8'h0D, 16'h00C3);
  endtask

  task automatic test_corners();
`ifdef MULT_SIGNED_EN
    run_op("mul_ff_ff", 8'hFF, 8'hFF, 16'h0001);
    run_op("mul_80_02", 8'h80, 8'h02, 16'hFF00);
`else
    run_op("mul_ff_ff", 8'hFF, 8'hFF, 16'hFE01);
    run_op("mul_80_02", 8'h80, 8'h02, 16'h0100);
`endif
    run_op("mul_00_aa", 8'h00, 8'hAA, 16'h0000);
  endtask

  // init and new operands arriving mid-operation must have no effect.
  task automatic test_ignore_init();
    start_op(8'h03, 8'h05);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin A = 8'h10; B = 8'h10; init = 1'b1; end
      if (i == 6) init = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL ignore busy at iter %0d: got %b, want 1", i, busy);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || PP !== 16'h000F) begin
      n_fail++;
      $display("FAIL ignore result: got done=%b PP=%h, want 1/000f", done, PP);
    end
    @(negedge clk);
    run_op("mul_10_10", 8'h10, 8'h10, 16'h0100);
  endtask

  // Reset mid-operation discards the in-flight result.
  task automatic test_reset_midop();
    start_op(8'h12, 8'h34);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (PP !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL midop reset: got PP=%h busy=%b done=%b st=%0d, want 0000/0/0/0",
               PP, busy, done, dbg_state);
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || PP !== 16'h0000) begin
      n_fail++;
      $display("FAIL midop stale: got done=%b PP=%h, want 0/0000", done, PP);
    end
    run_op("mul_12_34", 8'h12, 8'h34, 16'h03A8);
  endtask

  // init held high: operations restart every 10 cycles.
  task automatic test_back_to_back();
    @(negedge clk);
    A = 8'h0F; B = 8'h0D; init = 1'b1;
    @(negedge clk);
    repeat (8) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || PP !== 16'h00C3) begin
      n_fail++;
      $display("FAIL b2b first: got done=%b PP=%h, want 1/00c3", done, PP);
    end
    A = 8'h07; B = 8'h09;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b gap: got st=%0d busy=%b, want 0/0", dbg_state, busy);
    end
    @(negedge clk);
    init = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b restart: got busy=%b, want 1", busy);
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || PP !== 16'h003F) begin
      n_fail++;
      $display("FAIL b2b second: got done=%b PP=%h, want 1/003f", done, PP);
    end
    @(negedge clk);
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed();
    run_op("s_ff_02", 8'hFF, 8'h02, 16'hFFFE);
    run_op("s_80_80", 8'h80, 8'h80, 16'h4000);
    run_op("s_80_7f", 8'h80, 8'h7F, 16'hC080);
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0; init = 1'b0; A = '0; B = '0;
    test_reset();
    test_basic();
    test_corners();
    test_ignore_init();
    test_reset_midop();
    test_back_to_back();
`ifdef MULT_SIGNED_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
